mt_writeback_unit: RTL and testbench
====================================

# mt_writeback_unit

Write side of the multithreaded register file in the barrel core. Merges completed results from the ALU writeback stage and the load-return path into a single registered write port (`wb_we`/`wb_tid`/`wb_rd`/`wb_data`). The register file consumes this port directly. Load returns are buffered in a small FIFO, and a per-thread busy vector tells the thread scheduler which threads still have load results in flight.

## Interface
- `NUM_THREADS`, 8, hardware threads; power of two
- `DATA_WIDTH`, 32, register width
- `LQ_DEPTH`, 4, load-return FIFO entries; power of two, ≥2
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `alu_valid`  in  1  ALU result present this cycle; no backpressure
- `alu_tid`  in  clog2(NUM_THREADS)  ALU result thread
- `alu_rd`  in  5  ALU destination register
- `alu_data`  in  DATA_WIDTH  ALU result
- `mem_valid`  in  1  load return offered
- `mem_ready`  out  1  load return accepted when high with `mem_valid`
- `mem_tid`, `mem_rd`, `mem_data`  in  clog2(NUM_THREADS)/5/DATA_WIDTH  load return fields
- `wb_we`  out  1  register-file write enable
- `wb_tid`  out  clog2(NUM_THREADS)  write thread
- `wb_rd`  out  5  write register
- `wb_data`  out  DATA_WIDTH  write data
- `thread_busy`  out  NUM_THREADS  bit t set while thread t has buffered load writes
- `fwd_valid`, `fwd_tid`, `fwd_rd`, `fwd_data`  out  1/clog2(NUM_THREADS)/5/DATA_WIDTH  bypass copy of the write port; only with `MT_WB_BYPASS_EN`

## Operation
- **Reset values.** `rst_n` low clears all outputs, empties the FIFO, and zeroes the per-thread counters.
  - `mem_ready` = !full. It reads 1 during reset, but no push occurs while `rst_n` is low.
- **Write slot.** One write slot per cycle. An ALU result with `alu_valid && alu_rd != 0` always wins the slot.
- **ALU writes to x0.** An ALU result with `alu_rd == 0` is dropped and leaves the slot free.
- **Load push.** A push occurs when `mem_valid && mem_ready`. A load with `mem_rd == 0` is accepted and discarded: no FIFO entry and no counter change.
- **Load pop.** The FIFO head pops only in a cycle where the ALU does not claim the slot.
- **Ordering.** Writes from the FIFO leave in acceptance order. No ordering is enforced between ALU and load writes; the scheduler uses `thread_busy` to avoid the hazard.
- **Per-thread counters.** Each thread has a counter of width clog2(LQ_DEPTH+1).
  - Push of thread t: +1. Pop of thread t: −1.
  - Push and pop of the same thread in one cycle: counter unchanged.
  - `thread_busy[t]` = counter != 0, registered.
- **Full FIFO.** `mem_ready` is based on the registered occupancy. A pop in the same cycle does not enable a push, so there is no simultaneous push+pop when full.
- **Empty FIFO.** No pop and no `wb_we` from the load path.
- **FIFO pointers.** Read and write pointers wrap modulo `LQ_DEPTH`.

## Timing
- **ALU path.** `alu_valid` at cycle N → `wb_we` = 1 at N+1, with fields equal to the N inputs.
- **Load path.** A load accepted at N is at the FIFO head at N+1. Earliest `wb_we` is at N+2. Every cycle the ALU holds the slot delays it by one cycle.
- **Busy flag.** `thread_busy[t]` rises at N+1 after a push at N. It falls in the cycle `wb_we` carries that thread's last buffered write.
- **Write-port duty.** `wb_we` is a one-cycle pulse per write. Back-to-back writes are allowed every cycle.
- **Reset mid-operation.** Buffered loads are lost, and `wb_we` is 0 from the reset assertion onward.

## Configuration
- `MT_WB_BYPASS_EN` defined: the `fwd_*` ports exist.
  - They are combinational copies of the slot winner in the cycle before it appears on `wb_*`, i.e. the value being registered.
  - Operand fetch uses them to see a write one cycle early.
  - `fwd_valid` = 0 in reset.
- Undefined: no `fwd_*` ports, and no change to any other behaviour.

## Structure
- **Shared package `mt_pkg`.** Holds the `NUM_THREADS`/`DATA_WIDTH` defaults, the `tid_t` typedef, and the struct `wb_req_t {tid, rd, data}`. The ALU, load, write-port and bypass paths all use it.
- **Sub-module `mt_wb_fifo`.** Parameterised `LQ_DEPTH`-entry FIFO of `wb_req_t` with `full`/`empty` outputs.
- **Top level.** Holds arbitration, the per-thread counters and the output registers.

## Test plan
- **ALU only.** After reset, `alu_valid`=1, tid=3, rd=5, data=0xDEADBEEF at cycle 0 → cycle 1: `wb_we`=1, `wb_tid`=3, `wb_rd`=5, `wb_data`=0xDEADBEEF. `alu_rd`=0 → `wb_we` stays 0.
- **Load while slot is free.** Load tid=2, rd=7, data=0x1234 accepted at cycle 0 with no ALU traffic → `thread_busy[2]`=1 at cycle 1; write at cycle 2; `thread_busy[2]`=0 at cycle 2.
- **Priority.** Load accepted at cycle 0, ALU valid cycles 1–3 → ALU writes at cycles 2–4, load write at cycle 5.
- **Full FIFO.** ALU valid continuously, 5 loads offered → `mem_ready`=0 after 4 accepts. After ALU stops: 4 writes in order, then the 5th load is accepted.
- **Mixed threads / x0 / reset.** Same-thread push+pop keeps the counter. A `mem_rd`=0 load is accepted with no write and no busy. Reset asserted with 3 buffered loads → `wb_we`=0, all busy bits clear, FIFO empty after release.

Source files
------------

// File: rtl/mt_pkg.sv
// Shared types for the barrel-core register-file write side.
// Holds the default thread count and register width, the thread-id type and
// the write request record used by the ALU, load, write-port and bypass paths.
package mt_pkg;

    localparam int unsigned MT_NUM_THREADS = 8;
    localparam int unsigned MT_DATA_WIDTH  = 32;
    localparam int unsigned MT_TID_W       = $clog2(MT_NUM_THREADS);
    localparam int unsigned MT_RD_W        = 5;

    typedef logic [MT_TID_W-1:0] tid_t;

    typedef struct packed {
        tid_t                     tid;
        logic [MT_RD_W-1:0]       rd;
        logic [MT_DATA_WIDTH-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/mt_writeback_unit_if.sv
// Bus bundle for mt_writeback_unit.
//   alu_*        : ALU writeback results (no backpressure)
//   mem_*        : load-return handshake (mem_valid/mem_ready) and fields
//   wb_*         : registered register-file write port
//   thread_busy  : per-thread "loads still buffered" flags
//   fwd_*        : combinational bypass of the slot winner (MT_WB_BYPASS_EN only)
// master = core side driving results, slave = the writeback unit.
interface mt_wb_if #(
    parameter int unsigned NUM_THREADS = mt_pkg::MT_NUM_THREADS,
    parameter int unsigned DATA_WIDTH  = mt_pkg::MT_DATA_WIDTH
);
    localparam int unsigned TID_W = $clog2(NUM_THREADS);

    logic                   alu_valid;
    logic [TID_W-1:0]       alu_tid;
    logic [4:0]             alu_rd;
    logic [DATA_WIDTH-1:0]  alu_data;

    logic                   mem_valid;
    logic                   mem_ready;
    logic [TID_W-1:0]       mem_tid;
    logic [4:0]             mem_rd;
    logic [DATA_WIDTH-1:0]  mem_data;

    logic                   wb_we;
    logic [TID_W-1:0]       wb_tid;
    logic [4:0]             wb_rd;
    logic [DATA_WIDTH-1:0]  wb_data;

    logic [NUM_THREADS-1:0] thread_busy;

`ifdef MT_WB_BYPASS_EN
    logic                   fwd_valid;
    logic [TID_W-1:0]       fwd_tid;
    logic [4:0]             fwd_rd;
    logic [DATA_WIDTH-1:0]  fwd_data;

    modport master (
        output alu_valid, alu_tid, alu_rd, alu_data,
        output mem_valid, mem_tid, mem_rd, mem_data,
        input  mem_ready,
        input  wb_we, wb_tid, wb_rd, wb_data, thread_busy,
        input  fwd_valid, fwd_tid, fwd_rd, fwd_data
    );

    modport slave (
        input  alu_valid, alu_tid, alu_rd, alu_data,
        input  mem_valid, mem_tid, mem_rd, mem_data,
        output mem_ready,
        output wb_we, wb_tid, wb_rd, wb_data, thread_busy,
        output fwd_valid, fwd_tid, fwd_rd, fwd_data
    );
`else
    modport master (
        output alu_valid, alu_tid, alu_rd, alu_data,
        output mem_valid, mem_tid, mem_rd, mem_data,
        input  mem_ready,
        input  wb_we, wb_tid, wb_rd, wb_data, thread_busy
    );

    modport slave (
        input  alu_valid, alu_tid, alu_rd, alu_data,
        input  mem_valid, mem_tid, mem_rd, mem_data,
        output mem_ready,
        output wb_we, wb_tid, wb_rd, wb_data, thread_busy
    );
`endif

endinterface

// File: rtl/mt_wb_fifo.sv
// Load-return FIFO of wb_req_t entries.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push/push_data : enqueue (ignored when full)
//   pop/head       : dequeue / current head entry (head valid when !empty)
//   full, empty    : derived from the registered occupancy
module mt_wb_fifo
    import mt_pkg::*;
#(
    parameter int unsigned LQ_DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  wb_req_t push_data,
    input  logic    pop,
    output wb_req_t head,
    output logic    full,
    output logic    empty
);
    localparam int unsigned PtrW = $clog2(LQ_DEPTH);
    localparam int unsigned CntW = $clog2(LQ_DEPTH + 1);

    wb_req_t         mem_q [LQ_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            push_en, pop_en;

    assign full    = (count_q == CntW'(LQ_DEPTH));
    assign empty   = (count_q == '0);
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];

    // Storage needs no reset: entries are only read when count_q says so.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointers wrap naturally because LQ_DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop_en)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_q + CntW'(push_en) - CntW'(pop_en);
        end
    end

endmodule

// File: rtl/mt_writeback_unit.sv
// Register-file write side of the barrel core.
// Merges ALU results and buffered load returns into one registered write port.
// ALU results (rd != 0) always win the slot; the load FIFO head drains when
// the slot is free. Per-thread counters of buffered loads drive thread_busy.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mt_wb_if.slave (alu_*, mem_* handshake, wb_*, thread_busy, fwd_*)
// Optional: MT_WB_BYPASS_EN adds the fwd_* combinational copy of the slot winner.
module mt_writeback_unit
    import mt_pkg::*;
#(
    parameter int unsigned NUM_THREADS = MT_NUM_THREADS,
    parameter int unsigned DATA_WIDTH  = MT_DATA_WIDTH,
    parameter int unsigned LQ_DEPTH    = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    mt_wb_if.slave  bus
);
    localparam int unsigned TidW = $clog2(NUM_THREADS);
    localparam int unsigned CntW = $clog2(LQ_DEPTH + 1);

    wb_req_t alu_req, mem_req, head, slot;
    logic    alu_win, push, pop, slot_valid;
    logic    fifo_full, fifo_empty;

    logic [CntW-1:0]        cnt_q [NUM_THREADS];
    logic [CntW-1:0]        cnt_d [NUM_THREADS];
    logic [NUM_THREADS-1:0] busy_q, busy_d;
    logic                   wb_we_q;
    wb_req_t                wb_req_q;

    assign alu_req = '{tid: bus.alu_tid, rd: bus.alu_rd, data: bus.alu_data};
    assign mem_req = '{tid: bus.mem_tid, rd: bus.mem_rd, data: bus.mem_data};

    // Registered occupancy only: a same-cycle pop never frees room for a push.
    assign bus.mem_ready = !fifo_full;

    always_comb begin
        alu_win    = bus.alu_valid && (bus.alu_rd != '0);
        // Loads to x0 are accepted but never enqueued.
        push       = bus.mem_valid && !fifo_full && (bus.mem_rd != '0);
        pop        = !alu_win && !fifo_empty;
        slot_valid = alu_win || pop;
        slot       = alu_win ? alu_req : head;
    end

    mt_wb_fifo #(
        .LQ_DEPTH (LQ_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (mem_req),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Same-thread push and pop cancel out.
    always_comb begin
        for (int unsigned t = 0; t < NUM_THREADS; t++) begin
            cnt_d[t] = cnt_q[t];
            if (push && (mem_req.tid == TidW'(t))) cnt_d[t] = cnt_d[t] + CntW'(1);
            if (pop && (head.tid == TidW'(t)))     cnt_d[t] = cnt_d[t] - CntW'(1);
            busy_d[t] = (cnt_d[t] != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned t = 0; t < NUM_THREADS; t++) cnt_q[t] <= '0;
            busy_q   <= '0;
            wb_we_q  <= 1'b0;
            wb_req_q <= '0;
        end else begin
            for (int unsigned t = 0; t < NUM_THREADS; t++) cnt_q[t] <= cnt_d[t];
            busy_q  <= busy_d;
            wb_we_q <= slot_valid;
            if (slot_valid) wb_req_q <= slot;
        end
    end

    assign bus.wb_we       = wb_we_q;
    assign bus.wb_tid      = wb_req_q.tid;
    assign bus.wb_rd       = wb_req_q.rd;
    assign bus.wb_data     = wb_req_q.data;
    assign bus.thread_busy = busy_q;

`ifdef MT_WB_BYPASS_EN
    // The value about to be registered into wb_*; forced idle during reset.
    assign bus.fwd_valid = slot_valid && rst_n;
    assign bus.fwd_tid   = slot.tid;
    assign bus.fwd_rd    = slot.rd;
    assign bus.fwd_data  = slot.data;
`endif

endmodule

// File: tb/tb_mt_writeback_unit.sv
module tb_mt_writeback_unit;

    localparam int unsigned NT = 8;
    localparam int unsigned DW = 32;
    localparam int unsigned LQ = 4;

    typedef struct packed {
        logic [2:0]  tid;
        logic [4:0]  rd;
        logic [31:0] data;
    } rec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mt_wb_if #(.NUM_THREADS(NT), .DATA_WIDTH(DW)) bus ();

    mt_writeback_unit #(
        .NUM_THREADS (NT),
        .DATA_WIDTH  (DW),
        .LQ_DEPTH    (LQ)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   n_vec = 0;
    int   n_err = 0;
    rec_t lq_m[$];
    rec_t sb[$];
    int   cnt_m[NT];
    rec_t none = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [NT-1:0] busy_exp();
        logic [NT-1:0] b;
        for (int t = 0; t < NT; t++) b[t] = (cnt_m[t] != 0);
        return b;
    endfunction

    function automatic void model_clear();
        lq_m.delete();
        sb.delete();
        for (int t = 0; t < NT; t++) cnt_m[t] = 0;
    endfunction

    // One clock: drive at posedge+1, predict, advance, compare at posedge+1.
    task automatic cycle(input logic av, input rec_t a, input logic mv, input rec_t m,
                         output logic acc);
        logic ready_m, slot_v;
        rec_t slot, e;
        bus.alu_valid = av;
        bus.alu_tid   = a.tid;
        bus.alu_rd    = a.rd;
        bus.alu_data  = a.data;
        bus.mem_valid = mv;
        bus.mem_tid   = m.tid;
        bus.mem_rd    = m.rd;
        bus.mem_data  = m.data;
        ready_m = (lq_m.size() < LQ);
        #1;
        check("mem_ready", 64'(bus.mem_ready), 64'(ready_m));
        acc = mv && ready_m;
        slot_v = 1'b0;
        slot = '0;
        if (av && a.rd != 0) begin
            slot_v = 1'b1;
            slot = a;
        end else if (lq_m.size() > 0) begin
            slot_v = 1'b1;
            slot = lq_m.pop_front();
            cnt_m[slot.tid]--;
        end
        if (acc && m.rd != 0) begin
            lq_m.push_back(m);
            cnt_m[m.tid]++;
        end
`ifdef MT_WB_BYPASS_EN
        check("fwd_valid", 64'(bus.fwd_valid), 64'(slot_v));
        if (slot_v) check("fwd_req", 64'({bus.fwd_tid, bus.fwd_rd, bus.fwd_data}), 64'(slot));
`endif
        if (slot_v) sb.push_back(slot);
        @(posedge clk);
        #1;
        check("wb_we", 64'(bus.wb_we), 64'(slot_v));
        if (bus.wb_we && sb.size() > 0) begin
            e = sb.pop_front();
            check("wb_tid", 64'(bus.wb_tid), 64'(e.tid));
            check("wb_rd", 64'(bus.wb_rd), 64'(e.rd));
            check("wb_data", 64'(bus.wb_data), 64'(e.data));
        end
        sb.delete();
        check("thread_busy", 64'(bus.thread_busy), 64'(busy_exp()));
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) cycle(1'b0, none, 1'b0, none, acc);
    endtask

    function automatic rec_t mk(input int tid, input int rd, input logic [31:0] d);
        rec_t r;
        r.tid = 3'(tid);
        r.rd = 5'(rd);
        r.data = d;
        return r;
    endfunction

    initial begin
        logic acc;
        int   taken;
        rst_n = 1'b0;
        bus.alu_valid = 1'b0; bus.alu_tid = '0; bus.alu_rd = '0; bus.alu_data = '0;
        bus.mem_valid = 1'b0; bus.mem_tid = '0; bus.mem_rd = '0; bus.mem_data = '0;
        model_clear();
        #2;
        check("rst_wb_we", 64'(bus.wb_we), 64'd0);
        check("rst_busy", 64'(bus.thread_busy), 64'd0);
        check("rst_mem_ready", 64'(bus.mem_ready), 64'd1);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // ALU only, then ALU to x0
        cycle(1'b1, mk(3, 5, 32'hDEADBEEF), 1'b0, none, acc);
        check("alu_data", 64'(bus.wb_data), 64'hDEADBEEF);
        cycle(1'b1, mk(3, 0, 32'h1111), 1'b0, none, acc);
        check("alu_x0_we", 64'(bus.wb_we), 64'd0);
        idle(1);

        // Load while slot is free
        cycle(1'b0, none, 1'b1, mk(2, 7, 32'h1234), acc);
        check("load_busy_rise", 64'(bus.thread_busy[2]), 64'd1);
        idle(1);
        check("load_write", 64'({bus.wb_we, bus.wb_data}), {31'd0, 1'b1, 32'h1234});
        idle(1);

        // Priority: load at 0, ALU 1..3, load write at 5
        cycle(1'b0, none, 1'b1, mk(4, 9, 32'hAAAA0001), acc);
        for (int i = 0; i < 3; i++) cycle(1'b1, mk(i, i + 1, 32'hB0 + 32'(i)), 1'b0, none, acc);
        cycle(1'b0, none, 1'b0, none, acc);
        check("prio_load_late", 64'({bus.wb_we, bus.wb_data}), {31'd0, 1'b1, 32'hAAAA0001});
        idle(2);

        // Full FIFO: ALU continuous, 5 loads offered
        taken = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, mk(7, 1, 32'(i)), 1'b1, mk(taken, 10 + taken, 32'hC0 + 32'(taken)), acc);
            if (acc) taken++;
        end
        check("full_accepts", 64'(taken), 64'd4);
        for (int i = 0; i < 6 && taken < 5; i++) begin
            cycle(1'b0, none, 1'b1, mk(taken, 10 + taken, 32'hC0 + 32'(taken)), acc);
            if (acc) taken++;
        end
        check("fifth_accepted", 64'(taken), 64'd5);
        idle(6);

        // Same-thread push+pop, load to x0
        cycle(1'b0, none, 1'b1, mk(1, 3, 32'h51), acc);
        cycle(1'b0, none, 1'b1, mk(1, 4, 32'h52), acc);
        check("same_tid_busy", 64'(bus.thread_busy[1]), 64'd1);
        idle(2);
        cycle(1'b0, none, 1'b1, mk(6, 0, 32'h99), acc);
        check("x0_load_acc", 64'(acc), 64'd1);
        idle(2);

        // Reset with 3 buffered loads
        for (int i = 0; i < 3; i++) cycle(1'b1, mk(0, 2, 32'(i)), 1'b1, mk(i + 3, 8, 32'hD0), acc);
        rst_n = 1'b0;
        model_clear();
        #1;
        check("mid_rst_we", 64'(bus.wb_we), 64'd0);
        check("mid_rst_busy", 64'(bus.thread_busy), 64'd0);
        check("mid_rst_ready", 64'(bus.mem_ready), 64'd1);
`ifdef MT_WB_BYPASS_EN
        check("mid_rst_fwd", 64'(bus.fwd_valid), 64'd0);
`endif
        @(posedge clk); @(posedge clk); #1;
        check("rst_hold_we", 64'(bus.wb_we), 64'd0);
        rst_n = 1'b1;
        idle(3);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 9) < 6,
                  mk($urandom_range(0, 7), $urandom_range(0, 31), $urandom),
                  $urandom_range(0, 1) == 1,
                  mk($urandom_range(0, 7), $urandom_range(0, 31), $urandom), acc);
        end
        idle(8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
